// File: rtl/gpreg_sb_file_pkg.sv
// gpreg_sb_file_pkg: shared port counts, tag width and register/data types for the
// scoreboarded general-purpose register file.
package gpreg_sb_file_pkg;

    localparam int GPREG_READ_PORTS  = 3;
    localparam int GPREG_WRITE_PORTS = 2;
    localparam int GPREG_ISSUE_PORTS = 1;
    localparam int GPREG_NR_REGS     = 32;
    localparam int XLEN              = 64;
    localparam int SB_TAG_WIDTH      = 4;

    typedef logic [SB_TAG_WIDTH-1:0]          sb_tag_t;
    typedef logic [$clog2(GPREG_NR_REGS)-1:0] reg_t;
    typedef logic [XLEN-1:0]                  data_t;

endpackage

// File: rtl/gpreg_sb_file_if.sv
// gpreg_sb_file_if: read, issue-claim, commit-write and flush signals of the register file;
// master is the pipeline side, slave is the register file.
interface gpreg_sb_file_if import gpreg_sb_file_pkg::*; #(
    parameter int NR_READ_PORTS  = GPREG_READ_PORTS,
    parameter int NR_WRITE_PORTS = GPREG_WRITE_PORTS,
    parameter int NR_ISSUE_PORTS = GPREG_ISSUE_PORTS,
    parameter int NR_REGS        = GPREG_NR_REGS,
    parameter int DATA_WIDTH     = XLEN,
    parameter int TAG_WIDTH      = SB_TAG_WIDTH,
    parameter int REG_AW         = $clog2(NR_REGS),
    parameter int CNT_W          = $clog2(NR_REGS + 1)
);

    logic                                       flush_i;
    logic [NR_READ_PORTS-1:0][REG_AW-1:0]       r_reg_i;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]   r_data_o;
    logic [NR_READ_PORTS-1:0]                   r_ready_o;
    logic [NR_ISSUE_PORTS-1:0]                  is_en_i;
    logic [NR_ISSUE_PORTS-1:0][REG_AW-1:0]      is_reg_i;
    logic [NR_ISSUE_PORTS-1:0][TAG_WIDTH-1:0]   is_tag_i;
    logic [NR_WRITE_PORTS-1:0]                  w_en_i;
    logic [NR_WRITE_PORTS-1:0][REG_AW-1:0]      w_reg_i;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  w_data_i;
    logic [NR_WRITE_PORTS-1:0][TAG_WIDTH-1:0]   w_tag_i;
    logic [CNT_W-1:0]                           nr_pending_o;

    modport master (
        output flush_i, r_reg_i, is_en_i, is_reg_i, is_tag_i, w_en_i, w_reg_i, w_data_i, w_tag_i,
        input  r_data_o, r_ready_o, nr_pending_o
    );

    modport slave (
        input  flush_i, r_reg_i, is_en_i, is_reg_i, is_tag_i, w_en_i, w_reg_i, w_data_i, w_tag_i,
        output r_data_o, r_ready_o, nr_pending_o
    );

endinterface

// File: rtl/gpreg_bypass_mux.sv
// gpreg_bypass_mux: one read port; same-cycle commit data overrides storage (highest write
// port wins), x0 is hard-wired to zero and always ready.
module gpreg_bypass_mux #(
    parameter int NR_WRITE_PORTS = 2,
    parameter int REG_AW         = 5,
    parameter int DATA_WIDTH     = 64
) (
    input  logic [REG_AW-1:0]                      i_rd_reg,
    input  logic [DATA_WIDTH-1:0]                  i_st_data,
    input  logic                                   i_st_pend,
    input  logic [NR_WRITE_PORTS-1:0]              i_w_en,
    input  logic [NR_WRITE_PORTS-1:0][REG_AW-1:0]  i_w_reg,
    input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] i_w_data,
    output logic [DATA_WIDTH-1:0]                  o_data,
    output logic                                   o_ready
);

    logic w_is_x0;

    assign w_is_x0 = (i_rd_reg == '0);

    always_comb begin
        o_data  = i_st_data;
        o_ready = !i_st_pend;
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            if (i_w_en[j] && i_w_reg[j] == i_rd_reg) begin
                o_data  = i_w_data[j];
                o_ready = 1'b1;
            end
        end
        if (w_is_x0) begin
            o_data  = '0;
            o_ready = 1'b1;
        end
    end

endmodule

// File: rtl/gpreg_sb_file.sv
// gpreg_sb_file: general-purpose register file with write-to-read bypass and a tagged
// per-register pending scoreboard; flush drops ownership but keeps architectural data.
module gpreg_sb_file import gpreg_sb_file_pkg::*; #(
    parameter int NR_READ_PORTS  = GPREG_READ_PORTS,
    parameter int NR_WRITE_PORTS = GPREG_WRITE_PORTS,
    parameter int NR_ISSUE_PORTS = GPREG_ISSUE_PORTS,
    parameter int NR_REGS        = GPREG_NR_REGS,
    parameter int DATA_WIDTH     = XLEN,
    parameter int TAG_WIDTH      = SB_TAG_WIDTH,
    parameter int REG_AW         = $clog2(NR_REGS),
    parameter int CNT_W          = $clog2(NR_REGS + 1)
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    gpreg_sb_file_if.slave io_bus
);

    logic [DATA_WIDTH-1:0] r_data [NR_REGS];
    logic [TAG_WIDTH-1:0]  r_tag  [NR_REGS];
    logic [NR_REGS-1:0]    r_pend;
    logic [CNT_W-1:0]      r_nr_pending;

    logic [DATA_WIDTH-1:0] w_data_nxt [NR_REGS];
    logic [TAG_WIDTH-1:0]  w_tag_nxt  [NR_REGS];
    logic [NR_REGS-1:0]    w_pend_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;

    // Clears compare against the pre-edge tag; issues are applied last so they win.
    always_comb begin
        w_data_nxt = r_data;
        w_tag_nxt  = r_tag;
        w_pend_nxt = r_pend;
        for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            if (io_bus.w_en_i[j] && io_bus.w_reg_i[j] != '0) begin
                w_data_nxt[io_bus.w_reg_i[j]] = io_bus.w_data_i[j];
                if (r_pend[io_bus.w_reg_i[j]] && r_tag[io_bus.w_reg_i[j]] == io_bus.w_tag_i[j])
                    w_pend_nxt[io_bus.w_reg_i[j]] = 1'b0;
            end
        end
        if (io_bus.flush_i) begin
            w_pend_nxt = '0;
        end else begin
            for (int k = 0; k < NR_ISSUE_PORTS; k++) begin
                if (io_bus.is_en_i[k] && io_bus.is_reg_i[k] != '0) begin
                    w_pend_nxt[io_bus.is_reg_i[k]] = 1'b1;
                    w_tag_nxt[io_bus.is_reg_i[k]]  = io_bus.is_tag_i[k];
                end
            end
        end
    end

    always_comb begin
        w_cnt_nxt = '0;
        for (int r = 1; r < NR_REGS; r++) w_cnt_nxt = w_cnt_nxt + CNT_W'(w_pend_nxt[r]);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NR_REGS; r++) begin
                r_data[r] <= '0;
                r_tag[r]  <= '0;
            end
            r_pend       <= '0;
            r_nr_pending <= '0;
        end else begin
            for (int r = 0; r < NR_REGS; r++) begin
                r_data[r] <= w_data_nxt[r];
                r_tag[r]  <= w_tag_nxt[r];
            end
            r_pend       <= w_pend_nxt;
            r_nr_pending <= w_cnt_nxt;
        end
    end

    assign io_bus.nr_pending_o = r_nr_pending;

    for (genvar i = 0; i < NR_READ_PORTS; i++) begin : g_rd
        gpreg_bypass_mux #(
            .NR_WRITE_PORTS (NR_WRITE_PORTS),
            .REG_AW         (REG_AW),
            .DATA_WIDTH     (DATA_WIDTH)
        ) u_mux (
            .i_rd_reg  (io_bus.r_reg_i[i]),
            .i_st_data (r_data[io_bus.r_reg_i[i]]),
            .i_st_pend (r_pend[io_bus.r_reg_i[i]]),
            .i_w_en    (io_bus.w_en_i),
            .i_w_reg   (io_bus.w_reg_i),
            .i_w_data  (io_bus.w_data_i),
            .o_data    (io_bus.r_data_o[i]),
            .o_ready   (io_bus.r_ready_o[i])
        );
    end

endmodule

// File: tb/tb_gpreg_sb_file.sv
// tb_gpreg_sb_file: directed scenarios plus randomized traffic against an array-based
// reference model of the register file and scoreboard.
module tb_gpreg_sb_file;
    import gpreg_sb_file_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [63:0] md [32];
    bit          mp [32];
    logic [3:0]  mt [32];

    gpreg_sb_file_if bus ();

    gpreg_sb_file dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .io_bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic clear_inputs();
        bus.flush_i  = 1'b0;
        bus.r_reg_i  = '0;
        bus.is_en_i  = '0;
        bus.is_reg_i = '0;
        bus.is_tag_i = '0;
        bus.w_en_i   = '0;
        bus.w_reg_i  = '0;
        bus.w_data_i = '0;
        bus.w_tag_i  = '0;
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            md[r] = '0;
            mp[r] = 1'b0;
            mt[r] = '0;
        end
    endtask

    // Reference model: apply one clock edge's worth of commit/issue/flush rules.
    task automatic model_update();
        logic [63:0] nd [32];
        bit          np [32];
        logic [3:0]  nt [32];
        for (int r = 0; r < 32; r++) begin
            nd[r] = md[r];
            np[r] = mp[r];
            nt[r] = mt[r];
        end
        for (int j = 0; j < 2; j++) begin
            int wr;
            wr = int'(bus.w_reg_i[j]);
            if (bus.w_en_i[j] && wr != 0) begin
                nd[wr] = bus.w_data_i[j];
                if (mp[wr] && mt[wr] == bus.w_tag_i[j]) np[wr] = 1'b0;
            end
        end
        if (bus.flush_i) begin
            for (int r = 0; r < 32; r++) np[r] = 1'b0;
        end else if (bus.is_en_i[0] && bus.is_reg_i[0] != 0) begin
            np[int'(bus.is_reg_i[0])] = 1'b1;
            nt[int'(bus.is_reg_i[0])] = bus.is_tag_i[0];
        end
        for (int r = 0; r < 32; r++) begin
            md[r] = nd[r];
            mp[r] = np[r];
            mt[r] = nt[r];
        end
    endtask

    function automatic int model_count();
        int n;
        n = 0;
        for (int r = 0; r < 32; r++) n += int'(mp[r]);
        return n;
    endfunction

    function automatic void exp_read(input int r, output logic [63:0] d, output logic rdy);
        d   = md[r];
        rdy = !mp[r];
        for (int j = 0; j < 2; j++) begin
            if (bus.w_en_i[j] && int'(bus.w_reg_i[j]) == r) begin
                d   = bus.w_data_i[j];
                rdy = 1'b1;
            end
        end
        if (r == 0) begin
            d   = '0;
            rdy = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.nr_pending_o !== 6'd0) begin
            failures++;
            $display("FAIL reset_cnt_in_reset got=%0d exp=0", bus.nr_pending_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 1; r < 32; r++) begin
            for (int i = 0; i < 3; i++) bus.r_reg_i[i] = 5'(r);
            #1;
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (bus.r_data_o[i] !== 64'd0 || bus.r_ready_o[i] !== 1'b1) begin
                    failures++;
                    $display("FAIL reset_read x%0d port%0d got=%h/%b exp=0/1", r, i, bus.r_data_o[i], bus.r_ready_o[i]);
                end
            end
        end
        checks++;
        if (bus.nr_pending_o !== 6'd0) begin
            failures++;
            $display("FAIL reset_cnt got=%0d exp=0", bus.nr_pending_o);
        end
    endtask

    task automatic test_x0();
        clear_inputs();
        bus.w_en_i[0]   = 1'b1;
        bus.w_data_i[0] = 64'hDEAD;
        bus.is_en_i[0]  = 1'b1;
        #1;
        checks++;
        if (bus.r_data_o[0] !== 64'd0 || bus.r_ready_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL x0_bypass got=%h/%b exp=0/1", bus.r_data_o[0], bus.r_ready_o[0]);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (bus.r_data_o[0] !== 64'd0 || bus.r_ready_o[0] !== 1'b1 || bus.nr_pending_o !== 6'd0) begin
            failures++;
            $display("FAIL x0_stored got=%h/%b cnt=%0d exp=0/1 cnt=0", bus.r_data_o[0], bus.r_ready_o[0], bus.nr_pending_o);
        end
    endtask

    task automatic test_issue_write();
        clear_inputs();
        bus.is_en_i[0] = 1'b1; bus.is_reg_i[0] = 5'd5; bus.is_tag_i[0] = 4'd3;
        tick();
        clear_inputs();
        bus.r_reg_i[0] = 5'd5;
        #1;
        checks++;
        if (bus.r_ready_o[0] !== 1'b0 || bus.nr_pending_o !== 6'd1) begin
            failures++;
            $display("FAIL issue_pend got rdy=%b cnt=%0d exp rdy=0 cnt=1", bus.r_ready_o[0], bus.nr_pending_o);
        end
        bus.w_en_i[0] = 1'b1; bus.w_reg_i[0] = 5'd5; bus.w_data_i[0] = 64'h1234; bus.w_tag_i[0] = 4'd3;
        #1;
        checks++;
        if (bus.r_data_o[0] !== 64'h1234 || bus.r_ready_o[0] !== 1'b1) begin
            failures++;
            $display("FAIL write_bypass got=%h/%b exp=1234/1", bus.r_data_o[0], bus.r_ready_o[0]);
        end
        tick();
        clear_inputs();
        bus.r_reg_i[0] = 5'd5;
        #1;
        checks++;
        if (bus.r_data_o[0] !== 64'h1234 || bus.r_ready_o[0] !== 1'b1 || bus.nr_pending_o !== 6'd0) begin
            failures++;
            $display("FAIL write_clear got=%h/%b cnt=%0d exp=1234/1 cnt=0", bus.r_data_o[0], bus.r_ready_o[0], bus.nr_pending_o);
        end
    endtask

    task automatic test_reissue();
        clear_inputs();
        bus.is_en_i[0] = 1'b1; bus.is_reg_i[0] = 5'd7; bus.is_tag_i[0] = 4'd1;
        tick();
        bus.is_tag_i[0] = 4'd2;
        tick();
        clear_inputs();
        bus.w_en_i[1] = 1'b1; bus.w_reg_i[1] = 5'd7; bus.w_data_i[1] = 64'hAA; bus.w_tag_i[1] = 4'd1;
        tick();
        clear_inputs();
        bus.r_reg_i[2] = 5'd7;
        #1;
        checks++;
        if (bus.r_data_o[2] !== 64'hAA || bus.r_ready_o[2] !== 1'b0 || bus.nr_pending_o !== 6'd1) begin
            failures++;
            $display("FAIL stale_write got=%h/%b cnt=%0d exp=aa/0 cnt=1", bus.r_data_o[2], bus.r_ready_o[2], bus.nr_pending_o);
        end
        bus.w_en_i[0] = 1'b1; bus.w_reg_i[0] = 5'd7; bus.w_data_i[0] = 64'hBB; bus.w_tag_i[0] = 4'd2;
        tick();
        clear_inputs();
        bus.r_reg_i[2] = 5'd7;
        #1;
        checks++;
        if (bus.r_data_o[2] !== 64'hBB || bus.r_ready_o[2] !== 1'b1 || bus.nr_pending_o !== 6'd0) begin
            failures++;
            $display("FAIL owner_write got=%h/%b cnt=%0d exp=bb/1 cnt=0", bus.r_data_o[2], bus.r_ready_o[2], bus.nr_pending_o);
        end
    endtask

    task automatic test_same_reg();
        clear_inputs();
        bus.w_en_i = 2'b11;
        bus.w_reg_i[0] = 5'd9; bus.w_data_i[0] = 64'h11;
        bus.w_reg_i[1] = 5'd9; bus.w_data_i[1] = 64'h22;
        bus.r_reg_i[1] = 5'd9;
        #1;
        checks++;
        if (bus.r_data_o[1] !== 64'h22 || bus.r_ready_o[1] !== 1'b1) begin
            failures++;
            $display("FAIL dual_write_bypass got=%h/%b exp=22/1", bus.r_data_o[1], bus.r_ready_o[1]);
        end
        tick();
        clear_inputs();
        bus.r_reg_i[1] = 5'd9;
        #1;
        checks++;
        if (bus.r_data_o[1] !== 64'h22) begin
            failures++;
            $display("FAIL dual_write_store got=%h exp=22", bus.r_data_o[1]);
        end
        tick();
        bus.is_en_i[0] = 1'b1; bus.is_reg_i[0] = 5'd9; bus.is_tag_i[0] = 4'd5;
        tick();
        clear_inputs();
        bus.is_en_i[0] = 1'b1; bus.is_reg_i[0] = 5'd9; bus.is_tag_i[0] = 4'd5;
        bus.w_en_i[0] = 1'b1; bus.w_reg_i[0] = 5'd9; bus.w_data_i[0] = 64'h33; bus.w_tag_i[0] = 4'd5;
        tick();
        clear_inputs();
        bus.r_reg_i[0] = 5'd9;
        #1;
        checks++;
        if (bus.r_data_o[0] !== 64'h33 || bus.r_ready_o[0] !== 1'b0 || bus.nr_pending_o !== 6'd1) begin
            failures++;
            $display("FAIL issue_beats_write got=%h/%b cnt=%0d exp=33/0 cnt=1", bus.r_data_o[0], bus.r_ready_o[0], bus.nr_pending_o);
        end
        bus.w_en_i[1] = 1'b1; bus.w_reg_i[1] = 5'd9; bus.w_data_i[1] = 64'h44; bus.w_tag_i[1] = 4'd5;
        tick();
        clear_inputs();
        bus.r_reg_i[0] = 5'd9;
        #1;
        checks++;
        if (bus.r_ready_o[0] !== 1'b1 || bus.nr_pending_o !== 6'd0) begin
            failures++;
            $display("FAIL tag5_clear got rdy=%b cnt=%0d exp rdy=1 cnt=0", bus.r_ready_o[0], bus.nr_pending_o);
        end
    endtask

    task automatic test_flush();
        clear_inputs();
        for (int r = 1; r <= 3; r++) begin
            bus.is_en_i[0] = 1'b1; bus.is_reg_i[0] = 5'(r); bus.is_tag_i[0] = 4'(r);
            tick();
        end
        clear_inputs();
        #1;
        checks++;
        if (bus.nr_pending_o !== 6'd3) begin
            failures++;
            $display("FAIL flush_pre_cnt got=%0d exp=3", bus.nr_pending_o);
        end
        bus.flush_i = 1'b1;
        bus.is_en_i[0] = 1'b1; bus.is_reg_i[0] = 5'd4; bus.is_tag_i[0] = 4'd4;
        bus.w_en_i[0] = 1'b1; bus.w_reg_i[0] = 5'd2; bus.w_data_i[0] = 64'h55; bus.w_tag_i[0] = 4'd9;
        tick();
        clear_inputs();
        #1;
        checks++;
        if (bus.nr_pending_o !== 6'd0) begin
            failures++;
            $display("FAIL flush_cnt got=%0d exp=0", bus.nr_pending_o);
        end
        for (int r = 1; r <= 4; r++) begin
            bus.r_reg_i[0] = 5'(r);
            #1;
            checks++;
            if (bus.r_ready_o[0] !== 1'b1) begin
                failures++;
                $display("FAIL flush_ready x%0d got=%b exp=1", r, bus.r_ready_o[0]);
            end
        end
        bus.r_reg_i[0] = 5'd2;
        #1;
        checks++;
        if (bus.r_data_o[0] !== 64'h55) begin
            failures++;
            $display("FAIL flush_write x2 got=%h exp=55", bus.r_data_o[0]);
        end
    endtask

    task automatic test_random();
        logic [63:0] ed;
        logic        er;
        for (int n = 0; n < 400; n++) begin
            bus.flush_i = ($urandom_range(0, 15) == 0);
            bus.is_en_i[0]  = 1'($urandom);
            bus.is_reg_i[0] = 5'($urandom_range(0, 7));
            bus.is_tag_i[0] = 4'($urandom_range(0, 3));
            for (int j = 0; j < 2; j++) begin
                bus.w_en_i[j]   = 1'($urandom);
                bus.w_reg_i[j]  = 5'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : $urandom_range(0, 7));
                bus.w_data_i[j] = {$urandom, $urandom};
                bus.w_tag_i[j]  = 4'($urandom_range(0, 3));
            end
            for (int i = 0; i < 3; i++) bus.r_reg_i[i] = 5'($urandom_range(0, 8));
            #1;
            for (int i = 0; i < 3; i++) begin
                exp_read(int'(bus.r_reg_i[i]), ed, er);
                checks++;
                if (bus.r_data_o[i] !== ed || bus.r_ready_o[i] !== er) begin
                    failures++;
                    $display("FAIL rand_read n%0d port%0d x%0d got=%h/%b exp=%h/%b", n, i, bus.r_reg_i[i], bus.r_data_o[i], bus.r_ready_o[i], ed, er);
                end
            end
            tick();
            checks++;
            if (int'(bus.nr_pending_o) !== model_count()) begin
                failures++;
                $display("FAIL rand_cnt n%0d got=%0d exp=%0d", n, bus.nr_pending_o, model_count());
            end
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        bus.is_en_i[0] = 1'b1; bus.is_reg_i[0] = 5'd3; bus.is_tag_i[0] = 4'd1;
        bus.w_en_i[0] = 1'b1; bus.w_reg_i[0] = 5'd6; bus.w_data_i[0] = 64'h77;
        tick();
        bus.is_reg_i[0] = 5'd6;
        bus.w_en_i[0] = 1'b0;
        tick();
        clear_inputs();
        bus.r_reg_i[0] = 5'd3;
        bus.r_reg_i[1] = 5'd6;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.nr_pending_o !== 6'd0) begin
            failures++;
            $display("FAIL async_rst_cnt got=%0d exp=0", bus.nr_pending_o);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.r_data_o[i] !== 64'd0 || bus.r_ready_o[i] !== 1'b1) begin
                failures++;
                $display("FAIL async_rst_read port%0d got=%h/%b exp=0/1", i, bus.r_data_o[i], bus.r_ready_o[i]);
            end
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_x0();
        test_issue_write();
        test_reissue();
        test_same_reg();
        test_flush();
        test_random();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
